// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selectors and the count-bus width helper
// used by the FIFO and by anything that sizes a bus to carry its occupancy.
package fifo_pkg;

  localparam int FIFO_STANDARD   = 0;
  localparam int FIFO_SHOW_AHEAD = 1;

  // An occupancy of 0..depth needs one more code than depth itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_storage.sv
// Plain DEPTH x WIDTH register array: one synchronous write port and one
// asynchronous read port. Contents are deliberately left unreset.
module fifo_storage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             i_writeEn,
  input  logic [AW-1:0]    i_writeAddr,
  input  logic [WIDTH-1:0] i_writeData,
  input  logic [AW-1:0]    i_readAddr,
  output logic [WIDTH-1:0] o_readData
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_writeEn) begin
      r_mem[i_writeAddr] <= i_writeData;
    end
  end

  assign o_readData = r_mem[i_readAddr];

endmodule

// File: rtl/fifo_flagged.sv
// Synchronous FIFO with occupancy count, threshold flags, any depth >= 2,
// standard or show-ahead read, synchronous flush and sticky error flags.
module fifo_flagged
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 5,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int SHOW_AHEAD = FIFO_STANDARD
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      write_enable,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      read_update,
  output logic [WIDTH-1:0]          data_out,
  input  logic                      flush,
  input  logic                      clear_flags,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  generate
    if (DEPTH < 2) begin : g_badDepth
      $fatal(1, "fifo_flagged: DEPTH must be at least 2");
    end
    if (AF_LEVEL > DEPTH) begin : g_badAf
      $fatal(1, "fifo_flagged: AF_LEVEL must not exceed DEPTH");
    end
    if (AE_LEVEL >= DEPTH) begin : g_badAe
      $fatal(1, "fifo_flagged: AE_LEVEL must be below DEPTH");
    end
  endgenerate

  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_empty;
  logic             w_full;
  logic             w_writeAccept;
  logic             w_readAccept;
  logic             w_writeReject;
  logic             w_readReject;
  logic [WIDTH-1:0] w_rdData;

  // Flags come only from the count register, never from the inputs.
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == DEPTH_CNT);
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_count <= AE_CNT);
  assign almost_full  = (r_count >= AF_CNT);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Flush swallows any same-cycle request, so it never counts as an error.
  assign w_writeAccept = write_enable & ~w_full  & ~flush;
  assign w_readAccept  = read_update  & ~w_empty & ~flush;
  assign w_writeReject = write_enable &  w_full  & ~flush;
  assign w_readReject  = read_update  &  w_empty & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_writeAccept) begin
        r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PW'(1);
      end
      if (w_readAccept) begin
        r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PW'(1);
      end
      case ({w_writeAccept, w_readAccept})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A fresh error in the same cycle as clear_flags must survive the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow  & ~clear_flags) | w_writeReject;
      r_underflow <= (r_underflow & ~clear_flags) | w_readReject;
    end
  end

  fifo_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_storage (
    .clk         (clk),
    .i_writeEn   (w_writeAccept),
    .i_writeAddr (r_wrPtr),
    .i_writeData (data_in),
    .i_readAddr  (r_rdPtr),
    .o_readData  (w_rdData)
  );

  generate
    if (SHOW_AHEAD == FIFO_SHOW_AHEAD) begin : g_showAhead
      assign data_out = w_empty ? '0 : w_rdData;
    end else begin : g_standard
      logic [WIDTH-1:0] r_dataOut;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_dataOut <= '0;
        end else if (w_readAccept) begin
          r_dataOut <= w_rdData;
        end
      end

      assign data_out = r_dataOut;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_flagged.sv
// Self-checking bench for fifo_flagged: one standard and one show-ahead
// instance share stimulus and are checked against a queue-based model.
module tb_fifo_flagged;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;

  logic             clk;
  logic             reset;
  logic             write_enable;
  logic [WIDTH-1:0] data_in;
  logic             read_update;
  logic             flush;
  logic             clear_flags;

  logic [WIDTH-1:0] stdDataOut, saDataOut;
  logic [2:0]       stdCount, saCount;
  logic             stdEmpty, stdFull, stdAe, stdAf, stdOvf, stdUnf;
  logic             saEmpty, saFull, saAe, saAf, saOvf, saUnf;

  int nVectors;
  int nMiscompares;

  logic [WIDTH-1:0] modelQ[$];
  logic [WIDTH-1:0] expQ[$];
  logic [WIDTH-1:0] modelDout;
  logic             modelOvf;
  logic             modelUnf;

  fifo_flagged #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .SHOW_AHEAD(0)
  ) dutStd (
    .clk(clk), .reset(reset), .write_enable(write_enable), .data_in(data_in),
    .read_update(read_update), .data_out(stdDataOut), .flush(flush),
    .clear_flags(clear_flags), .count(stdCount), .empty(stdEmpty), .full(stdFull),
    .almost_empty(stdAe), .almost_full(stdAf), .overflow(stdOvf), .underflow(stdUnf)
  );

  fifo_flagged #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .SHOW_AHEAD(1)
  ) dutSa (
    .clk(clk), .reset(reset), .write_enable(write_enable), .data_in(data_in),
    .read_update(read_update), .data_out(saDataOut), .flush(flush),
    .clear_flags(clear_flags), .count(saCount), .empty(saEmpty), .full(saFull),
    .almost_empty(saAe), .almost_full(saAf), .overflow(saOvf), .underflow(saUnf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nVectors++;
    if (observed !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compares both instances against the model state after an edge.
  task automatic checkAll(input string tag);
    int n;
    logic [WIDTH-1:0] want;
    n = modelQ.size();
    checkOutput({tag, ".count"}, 32'(stdCount), 32'(n));
    checkOutput({tag, ".empty"}, 32'(stdEmpty), 32'(n == 0));
    checkOutput({tag, ".full"},  32'(stdFull),  32'(n == DEPTH));
    checkOutput({tag, ".ae"},    32'(stdAe),    32'(n <= AE));
    checkOutput({tag, ".af"},    32'(stdAf),    32'(n >= AF));
    checkOutput({tag, ".ovf"},   32'(stdOvf),   32'(modelOvf));
    checkOutput({tag, ".unf"},   32'(stdUnf),   32'(modelUnf));
    if (expQ.size() > 0) begin
      want = expQ.pop_front();
      checkOutput({tag, ".rdata"}, 32'(stdDataOut), 32'(want));
    end else begin
      checkOutput({tag, ".hold"}, 32'(stdDataOut), 32'(modelDout));
    end
    checkOutput({tag, ".saCount"}, 32'(saCount), 32'(n));
    checkOutput({tag, ".saData"}, 32'(saDataOut), (n > 0) ? 32'(modelQ[0]) : 32'h0);
  endtask

  // Drives one cycle of requests, advances the model on pre-edge state, then checks.
  task automatic applyStimulus(input string tag, input logic we, input logic [WIDTH-1:0] din,
                               input logic rd, input logic fl, input logic cf);
    logic wasFull, wasEmpty;
    logic [WIDTH-1:0] popped;
    @(negedge clk);
    write_enable = we;
    data_in      = din;
    read_update  = rd;
    flush        = fl;
    clear_flags  = cf;
    wasFull  = (modelQ.size() == DEPTH);
    wasEmpty = (modelQ.size() == 0);
    @(posedge clk);
    if (fl) begin
      modelQ.delete();
    end else begin
      if (rd && !wasEmpty) begin
        popped = modelQ.pop_front();
        expQ.push_back(popped);
        modelDout = popped;
      end
      if (we && !wasFull) modelQ.push_back(din);
    end
    if (cf) begin
      modelOvf = 1'b0;
      modelUnf = 1'b0;
    end
    if (we && wasFull && !fl) modelOvf = 1'b1;
    if (rd && wasEmpty && !fl) modelUnf = 1'b1;
    #1;
    checkAll(tag);
    write_enable = 1'b0;
    read_update  = 1'b0;
    flush        = 1'b0;
    clear_flags  = 1'b0;
  endtask

  task automatic resetModel();
    modelQ.delete();
    expQ.delete();
    modelDout = '0;
    modelOvf  = 1'b0;
    modelUnf  = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    nVectors     = 0;
    nMiscompares = 0;
    reset        = 1'b0;
    write_enable = 1'b0;
    data_in      = '0;
    read_update  = 1'b0;
    flush        = 1'b0;
    clear_flags  = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] fill to full");
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i * 8'h11);
      applyStimulus("fill", 1'b1, d, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus("ovfWrite", 1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus("clearOvf", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    $display("[TB] pointer wrap");
    for (int i = 0; i < 3; i++) applyStimulus("pre", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("preRd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus("wrap", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus("fullWrRd", 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("wrapRd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus("clearOvf2", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    $display("[TB] simultaneous read/write");
    applyStimulus("sim0", 1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    applyStimulus("sim1", 1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("both", 1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus("bothRd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] underflow and flush");
    applyStimulus("unfRead", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus("unfClr", 1'b0, '0, 1'b1, 1'b0, 1'b1);
    applyStimulus("clearUnf", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus("preFl", 1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus("flushWr", 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    applyStimulus("flushRd", 1'b0, '0, 1'b1, 1'b1, 1'b0);

    $display("[TB] show-ahead and async reset");
    applyStimulus("sa5A", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    applyStimulus("saIdle", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus("saRd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("saFill", 1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus("stdRd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus("saW", 1'b1, 8'hB3, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    resetModel();
    checkAll("asyncRst");
    @(negedge clk);
    reset = 1'b1;
    applyStimulus("postRst", 1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    applyStimulus("postRstRd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/fifo_flagged.md
Name: fifo_flagged

Overview:
Parametrised synchronous FIFO that succeeds the basic Fifo block. Adds explicit entry count, almost-full/almost-empty thresholds, non-power-of-two depth, selectable standard or show-ahead read mode, synchronous flush, and sticky overflow/underflow error flags. It buffers activations and weights between the memory interface and the neuron-array pipeline.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 5, number of entries (>=2, any value, not restricted to a power of two)
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL
SHOW_AHEAD, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
write_enable  input  1  push request
data_in  input  WIDTH  push data
read_update  input  1  pop request
data_out  output  WIDTH  read data
flush  input  1  synchronous discard of all contents
clear_flags  input  1  synchronous clear of overflow/underflow
count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_empty  output  1  count <= AE_LEVEL
almost_full  output  1  count >= AF_LEVEL
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=rd_ptr=0, count=0, data_out=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), overflow=underflow=0. Storage contents are don't-care. A reset asserted mid-transfer discards all data immediately, with no clock edge needed.
- Accept rules are evaluated on the pre-edge state. write_accept = write_enable & !full. read_accept = read_update & !empty.
- Full + write_enable: the write is rejected even if a read is accepted in the same cycle. overflow is set at that edge.
- Empty + read_update: the read is rejected and there is no bypass from data_in. underflow is set at that edge.
- Pointers advance by 1 and wrap explicitly from DEPTH-1 to 0. There is no power-of-two masking.
- Count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- All flags are decoded from the count register. There is no combinational path from any input to any flag.
- Latency: a write into an empty FIFO clears empty after 1 edge. A read at count 1 sets empty after 1 edge.
- SHOW_AHEAD=0: data_out is a register. It loads mem[rd_ptr] on the edge where read_accept is true, and otherwise holds its value (including on rejected reads). Data is valid the cycle after the pop.
- SHOW_AHEAD=1: data_out = mem[rd_ptr] whenever !empty, and 0 when empty. The first word appears the cycle after it is written, and read_update acknowledges and consumes it.
- flush=1: rd_ptr=wr_ptr=0 and count=0 on the next edge. flush has priority over a simultaneous write or read, and those requests are dropped without setting error flags. In standard mode data_out holds. Sticky flags are unaffected by flush.
- clear_flags=1 clears overflow/underflow on the next edge. If a new error occurs in the same cycle, the set wins.
- Parameter checks at elaboration (fatal): DEPTH<2, AF_LEVEL>DEPTH, AE_LEVEL>=DEPTH.

Decomposition:
- fifo_pkg holds the read-mode constants (FIFO_STANDARD=0, FIFO_SHOW_AHEAD=1) and a count-width function cnt_w(depth)=$clog2(depth+1), shared by consumers sizing count buses.
- One sub-module, fifo_storage: a DEPTH x WIDTH register array with one write port and one asynchronous read port, no reset on its contents.
- Pointer, count, flag and output logic stay in fifo_flagged.

Test Plan:
- Configuration for all scenarios unless noted: WIDTH=8, DEPTH=5, AF_LEVEL=4, AE_LEVEL=1, SHOW_AHEAD=0.
- Reset, then write 0x11,0x22,0x33,0x44,0x55 on consecutive edges -> count 1..5, almost_empty drops at count 2, almost_full rises at count 4, full=1 at count 5.
- While full, write 0x66 -> count stays 5, overflow=1. Then 5 reads return 0x11..0x55 in order, with the 0x66 write lost; empty=1 afterwards. Pulse clear_flags -> overflow=0.
- Write 3, read 3, then write 0xA0..0xA4 (pointers wrap 4->0) -> reads return 0xA0..0xA4 in order and full is reached exactly at count 5.
- At count 2, assert write_enable and read_update together for 3 cycles -> count stays 2 and the output order matches write order.
- Read while empty -> underflow=1 and data_out holds its previous value. Assert flush at count 3 together with write_enable -> count=0, empty=1 after 1 edge, no overflow.
- With SHOW_AHEAD=1, write 0x5A to an empty FIFO -> data_out=0x5A the next cycle with no read. Drive reset=0 mid-stream at count 3 -> count=0, empty=1 and data_out=0 before the next clk edge.
